// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// Provides state encodings, source count and select width.
package arb_defs;

    localparam int N_SRC = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set req at or after ptr.
// Ports: req[7:0], ptr[2:0] in; any (some req set), idx[2:0] winner out.
module rr_picker
    import arb_defs::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [N_SRC-1:0] rot;
    logic [SEL_W-1:0] off;

    always_comb begin
        // rot[i] is the request i places after ptr (wrapping)
        for (int i = 0; i < N_SRC; i++) begin
            rot[i] = req[SEL_W'(ptr + SEL_W'(i))];
        end
        off = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        any = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for one shared 8:1 mux with hold timer and handover gap.
// Ports: clk, rst_n, req[7:0] in; sel[2:0], gnt[7:0], valid, busy out.
module rr_mux_arbiter
    import arb_defs::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_SRC-1:0] gnt,
    output logic             valid,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             rel_w;
    logic             others_w;
    logic             sat_w;

    rr_picker u_picker (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        rel_w    = ~req[sel_q];
        others_w = |(req & ~gnt_q);
        sat_w    = (hold_q == CNT_W'(MAX_HOLD - 1));

        unique case (state_q)
            ST_GRANT: begin
                // release and preempt collapse into the same single gap
                if (rel_w || (sat_w && others_w)) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end else if (!sat_w) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and the gap exit both arbitrate
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = N_SRC'(1) << pick_idx;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    ptr_d   = pick_idx + SEL_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign sel   = sel_q;
    assign gnt   = gnt_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule
